// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions used by the client arbiter: opcodes,
// beat arithmetic and the A/D field bundles.
package tl_ul_pkg;

    localparam logic [2:0] OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // Wide enough for 2^(15-2) beats on a 32-bit bus.
    localparam int BEAT_W = 14;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_fields_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        denied;
        logic [31:0] data;
    } tl_d_fields_t;

    // A channel: Put messages carry data; D channel: only AccessAckData does.
    function automatic logic [BEAT_W-1:0] beats_from_size(input logic [2:0] opcode,
                                                          input logic [3:0] size,
                                                          input logic d_chan = 1'b0);
        logic multi;
        if (d_chan) multi = (opcode == OP_ACCESS_ACK_DATA);
        else        multi = (opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL);
        if (multi && (size > 4'd2)) return BEAT_W'(1) << (size - 4'd2);
        return BEAT_W'(1);
    endfunction

endpackage

// File: rtl/tl_client_arbiter_beat_counter.sv
// Tracks position inside a multi-beat TileLink message and flags its
// first and last beats.
module tl_beat_counter
    import tl_ul_pkg::*;
#(
    parameter bit D_CHAN = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [3:0] size,
    input  logic       fire,
    output logic       first,
    output logic       last
);

    logic [BEAT_W-1:0] beats_left;
    logic [BEAT_W-1:0] beats;

    always_comb begin
        beats = beats_from_size(opcode, size, D_CHAN);
        first = (beats_left == '0);
        last  = first ? (beats == BEAT_W'(1)) : (beats_left == BEAT_W'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beats_left <= '0;
        end else if (fire) begin
            beats_left <= first ? (beats - BEAT_W'(1)) : (beats_left - BEAT_W'(1));
        end
    end

endmodule

// File: rtl/tl_client_arbiter.sv
// Two-client TileLink-UL arbiter: round-robin A arbitration with burst lock,
// source tagging by client index, tag-steered D return, per-client credit limit.
module tl_client_arbiter
    import tl_ul_pkg::*;
#(
    parameter int SRC_BITS  = 4,
    parameter int ADDR_BITS = 14,
    parameter int MAX_OUT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                ua_valid,
    output logic [1:0]                ua_ready,
    input  logic [1:0][2:0]           ua_opcode,
    input  logic [1:0][2:0]           ua_param,
    input  logic [1:0][3:0]           ua_size,
    input  logic [1:0][SRC_BITS-2:0]  ua_source,
    input  logic [1:0][ADDR_BITS-1:0] ua_address,
    input  logic [1:0][3:0]           ua_mask,
    input  logic [1:0][31:0]          ua_data,
    output logic                      da_valid,
    input  logic                      da_ready,
    output logic [2:0]                da_opcode,
    output logic [2:0]                da_param,
    output logic [3:0]                da_size,
    output logic [SRC_BITS-1:0]       da_source,
    output logic [ADDR_BITS-1:0]      da_address,
    output logic [3:0]                da_mask,
    output logic [31:0]               da_data,
    input  logic                      dd_valid,
    output logic                      dd_ready,
    input  logic [2:0]                dd_opcode,
    input  logic [1:0]                dd_param,
    input  logic [3:0]                dd_size,
    input  logic [SRC_BITS-1:0]       dd_source,
    input  logic                      dd_denied,
    input  logic [31:0]               dd_data,
    output logic [1:0]                ud_valid,
    input  logic [1:0]                ud_ready,
    output logic [1:0][2:0]           ud_opcode,
    output logic [1:0][1:0]           ud_param,
    output logic [1:0][3:0]           ud_size,
    output logic [1:0][SRC_BITS-2:0]  ud_source,
    output logic [1:0]                ud_denied,
    output logic [1:0][31:0]          ud_data,
    output logic                      busy,
    output logic [0:0]                arb_state
);

    // Handshake: a beat transfers on a cycle where valid and ready are both high;
    // valid never waits on ready, and a presented beat is held until it transfers.

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUT);

    logic [0:0]      state;
    logic            last;
    logic            lock_id;
    logic            hold_q;
    logic            hold_id;
    logic [1:0][2:0] out_cnt;
    logic [1:0]      elig;
    logic            gnt_any;
    logic            gnt_id;
    logic            a_fire, a_first, a_last;
    logic            d_fire, d_last, d_first_unused;
    logic            d_id;
    logic [1:0]      inc, dec;
    tl_a_fields_t    a_sel;
    tl_d_fields_t    d_in;

    always_comb begin
        for (int i = 0; i < 2; i++) elig[i] = ua_valid[i] & (out_cnt[i] < MAX_CNT);
        gnt_id  = 1'b0;
        gnt_any = 1'b0;
        if (state == ST_BURST) begin
            gnt_id  = lock_id;
            gnt_any = ua_valid[lock_id];
        end else if (hold_q) begin
            // A stalled offer keeps its grant so da_* stays stable under backpressure.
            gnt_id  = hold_id;
            gnt_any = ua_valid[hold_id];
        end else if (&elig) begin
            gnt_id  = ~last;
            gnt_any = 1'b1;
        end else begin
            gnt_id  = elig[1];
            gnt_any = |elig;
        end
        if (reset) gnt_any = 1'b0;
    end

    always_comb begin
        a_sel = '{opcode: ua_opcode[gnt_id], param: ua_param[gnt_id], size: ua_size[gnt_id],
                  mask: ua_mask[gnt_id], data: ua_data[gnt_id]};
        da_valid   = gnt_any;
        da_opcode  = a_sel.opcode;
        da_param   = a_sel.param;
        da_size    = a_sel.size;
        da_mask    = a_sel.mask;
        da_data    = a_sel.data;
        da_address = ua_address[gnt_id];
        da_source  = {gnt_id, ua_source[gnt_id]};
        ua_ready[0] = da_ready & gnt_any & ~gnt_id;
        ua_ready[1] = da_ready & gnt_any & gnt_id;
        a_fire      = da_valid & da_ready;
    end

    tl_beat_counter #(.D_CHAN(1'b0)) u_a_beats (
        .clock  (clock),
        .reset  (reset),
        .opcode (da_opcode),
        .size   (da_size),
        .fire   (a_fire),
        .first  (a_first),
        .last   (a_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            last    <= 1'b1;
            lock_id <= 1'b0;
            hold_q  <= 1'b0;
            hold_id <= 1'b0;
        end else if (a_fire) begin
            hold_q <= 1'b0;
            if (a_first) begin
                last    <= gnt_id;
                lock_id <= gnt_id;
            end
            state <= a_last ? ST_IDLE : ST_BURST;
        end else if (state == ST_IDLE) begin
            hold_q  <= da_valid;
            hold_id <= gnt_id;
        end
    end

    // D return path: the top source bit names the client.
    always_comb begin
        d_id     = dd_source[SRC_BITS-1];
        d_in     = '{opcode: dd_opcode, param: dd_param, size: dd_size,
                     denied: dd_denied, data: dd_data};
        dd_ready = ud_ready[d_id] & ~reset;
        d_fire   = dd_valid & dd_ready;
        for (int i = 0; i < 2; i++) begin
            ud_valid[i]  = dd_valid & (d_id == i[0]) & ~reset;
            ud_opcode[i] = d_in.opcode;
            ud_param[i]  = d_in.param;
            ud_size[i]   = d_in.size;
            ud_denied[i] = d_in.denied;
            ud_data[i]   = d_in.data;
            ud_source[i] = dd_source[SRC_BITS-2:0];
        end
    end

    tl_beat_counter #(.D_CHAN(1'b1)) u_d_beats (
        .clock  (clock),
        .reset  (reset),
        .opcode (dd_opcode),
        .size   (dd_size),
        .fire   (d_fire),
        .first  (d_first_unused),
        .last   (d_last)
    );

    always_comb begin
        inc[0] = a_fire & a_first & ~gnt_id;
        inc[1] = a_fire & a_first & gnt_id;
        dec[0] = d_fire & d_last & ~d_id;
        dec[1] = d_fire & d_last & d_id;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (inc[i] && !dec[i])      out_cnt[i] <= out_cnt[i] + 3'd1;
                else if (dec[i] && !inc[i]) out_cnt[i] <= out_cnt[i] - 3'd1;
            end
        end
    end

    assign busy      = (state != ST_IDLE) | (|out_cnt);
    assign arb_state = state;

endmodule

// File: tb/tb_tl_client_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of the two-client arbiter.
module tb_tl_client_arbiter;

    localparam int SRC_BITS  = 4;
    localparam int ADDR_BITS = 14;
    localparam int MAX_OUT   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0]        ua_valid, ua_ready;
    logic [1:0][2:0]   ua_opcode, ua_param;
    logic [1:0][3:0]   ua_size, ua_mask;
    logic [1:0][2:0]   ua_source;
    logic [1:0][13:0]  ua_address;
    logic [1:0][31:0]  ua_data;
    logic              da_valid, da_ready;
    logic [2:0]        da_opcode, da_param;
    logic [3:0]        da_size, da_source, da_mask;
    logic [13:0]       da_address;
    logic [31:0]       da_data;
    logic              dd_valid, dd_ready, dd_denied;
    logic [2:0]        dd_opcode;
    logic [1:0]        dd_param;
    logic [3:0]        dd_size, dd_source;
    logic [31:0]       dd_data;
    logic [1:0]        ud_valid, ud_ready, ud_denied;
    logic [1:0][2:0]   ud_opcode, ud_source;
    logic [1:0][1:0]   ud_param;
    logic [1:0][3:0]   ud_size;
    logic [1:0][31:0]  ud_data;
    logic              busy;
    logic [0:0]        arb_state;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    // Reference model state for the randomized run
    int m_last, m_lock, m_hold, m_burst_left;
    int m_out[2];
    bit g_act[2];
    logic [2:0]  g_op[2], g_src[2];
    logic [3:0]  g_size[2], g_mask[2];
    logic [13:0] g_addr[2];
    logic [31:0] g_data[2];
    int g_left[2];
    bit d_act;
    logic [3:0]  d_src, d_size;
    logic [2:0]  d_op;
    logic [31:0] d_data;
    int d_left;

    tl_client_arbiter #(.SRC_BITS(SRC_BITS), .ADDR_BITS(ADDR_BITS), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset(reset),
        .ua_valid(ua_valid), .ua_ready(ua_ready), .ua_opcode(ua_opcode), .ua_param(ua_param),
        .ua_size(ua_size), .ua_source(ua_source), .ua_address(ua_address), .ua_mask(ua_mask),
        .ua_data(ua_data),
        .da_valid(da_valid), .da_ready(da_ready), .da_opcode(da_opcode), .da_param(da_param),
        .da_size(da_size), .da_source(da_source), .da_address(da_address), .da_mask(da_mask),
        .da_data(da_data),
        .dd_valid(dd_valid), .dd_ready(dd_ready), .dd_opcode(dd_opcode), .dd_param(dd_param),
        .dd_size(dd_size), .dd_source(dd_source), .dd_denied(dd_denied), .dd_data(dd_data),
        .ud_valid(ud_valid), .ud_ready(ud_ready), .ud_opcode(ud_opcode), .ud_param(ud_param),
        .ud_size(ud_size), .ud_source(ud_source), .ud_denied(ud_denied), .ud_data(ud_data),
        .busy(busy), .arb_state(arb_state)
    );

    always #5 clock = ~clock;

    function automatic int a_beats(logic [2:0] op, logic [3:0] sz);
        return (op <= 3'd1 && sz > 4'd2) ? (1 << (int'(sz) - 2)) : 1;
    endfunction

    function automatic int d_beats(logic [2:0] op, logic [3:0] sz);
        return (op == 3'd1 && sz > 4'd2) ? (1 << (int'(sz) - 2)) : 1;
    endfunction

    function automatic int exp_grant();
        bit e0, e1;
        if (m_burst_left > 0) return ua_valid[m_lock] ? m_lock : -1;
        if (m_hold >= 0) return ua_valid[m_hold] ? m_hold : -1;
        e0 = ua_valid[0] && (m_out[0] < MAX_OUT);
        e1 = ua_valid[1] && (m_out[1] < MAX_OUT);
        if (e0 && e1) return (m_last == 0) ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic idle_inputs();
        ua_valid = '0; ua_opcode = '0; ua_param = '0; ua_size = '0; ua_source = '0;
        ua_address = '0; ua_mask = '0; ua_data = '0; da_ready = 1'b0;
        dd_valid = 1'b0; dd_opcode = '0; dd_param = '0; dd_size = '0; dd_source = '0;
        dd_denied = 1'b0; dd_data = '0; ud_ready = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic set_get(input int c, input logic [2:0] src, input logic [13:0] addr);
        ua_opcode[c] = 3'd4; ua_size[c] = 4'd2; ua_source[c] = src; ua_address[c] = addr;
        ua_mask[c] = 4'hF; ua_data[c] = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (da_valid !== 1'b0) begin failures++; $display("FAIL reset_da_valid: got %b want 0", da_valid); end
        checks++; if (ud_valid !== 2'b00) begin failures++; $display("FAIL reset_ud_valid: got %b want 00", ud_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (arb_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %b want 0", arb_state); end
        ua_valid = 2'b11; set_get(0, 3'd1, 14'h10); set_get(1, 3'd2, 14'h20); da_ready = 1'b1;
        #1;
        checks++; if (da_valid !== 1'b0 || ua_ready !== 2'b00) begin failures++; $display("FAIL reset_gated: got da_valid=%b ua_ready=%b want 0/00", da_valid, ua_ready); end
        idle_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_alternate();
        logic [3:0] exp;
        apply_reset();
        ua_valid = 2'b11; set_get(0, 3'd5, 14'h100); set_get(1, 3'd2, 14'h200); da_ready = 1'b1;
        exp_q = '{4'h5, 4'hA, 4'h5, 4'hA};
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            checks++; if (da_valid !== 1'b1 || da_source !== exp) begin failures++; $display("FAIL alt_source: got v=%b src=%h want v=1 src=%h", da_valid, da_source, exp); end
            checks++; if (ua_ready !== (exp[3] ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_ready: got %b want %b", ua_ready, exp[3] ? 2'b10 : 2'b01); end
            checks++; if (da_address !== (exp[3] ? 14'h200 : 14'h100)) begin failures++; $display("FAIL alt_addr: got %h want %h", da_address, exp[3] ? 14'h200 : 14'h100); end
            next_cycle();
        end
        ua_valid = 2'b00;
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL alt_busy: got %b want 1", busy); end
    endtask

    task automatic test_burst_lock();
        apply_reset();
        ua_valid = 2'b11; da_ready = 1'b1;
        ua_opcode[0] = 3'd0; ua_size[0] = 4'd4; ua_source[0] = 3'd1; ua_address[0] = 14'h300; ua_mask[0] = 4'hF;
        set_get(1, 3'd6, 14'h340);
        for (int b = 0; b < 4; b++) begin
            ua_data[0] = 32'hD000_0000 + 32'(b);
            @(negedge clock);
            checks++; if (da_source !== 4'h1 || da_data !== 32'hD000_0000 + 32'(b)) begin failures++; $display("FAIL burst_beat%0d: got src=%h data=%h want src=1 data=%h", b, da_source, da_data, 32'hD000_0000 + 32'(b)); end
            checks++; if (arb_state !== ((b != 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL burst_state%0d: got %b want %b", b, arb_state, b != 0); end
            next_cycle();
        end
        ua_opcode[0] = 3'd4; ua_size[0] = 4'd2;
        @(negedge clock);
        checks++; if (da_source !== 4'hE || arb_state !== 1'b0) begin failures++; $display("FAIL burst_release: got src=%h state=%b want E/0", da_source, arb_state); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        ua_valid = 2'b01; set_get(0, 3'd3, 14'h20); da_ready = 1'b1;
        @(negedge clock);
        checks++; if (da_source !== 4'h3) begin failures++; $display("FAIL bp_first: got %h want 3", da_source); end
        next_cycle();
        set_get(0, 3'd4, 14'h24); da_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin ua_valid = 2'b11; set_get(1, 3'd7, 14'h30); end
            @(negedge clock);
            checks++; if (da_valid !== 1'b1 || da_source !== 4'h4 || da_address !== 14'h24 || ua_ready !== 2'b00) begin
                failures++; $display("FAIL bp_hold%0d: got v=%b src=%h addr=%h rdy=%b want 1/4/024/00", c, da_valid, da_source, da_address, ua_ready);
            end
            next_cycle();
        end
        da_ready = 1'b1;
        @(negedge clock);
        checks++; if (da_source !== 4'h4 || ua_ready !== 2'b01) begin failures++; $display("FAIL bp_accept: got src=%h rdy=%b want 4/01", da_source, ua_ready); end
        next_cycle();
        ua_valid = 2'b10;
        @(negedge clock);
        checks++; if (da_source !== 4'hF || ua_ready !== 2'b10) begin failures++; $display("FAIL bp_next: got src=%h rdy=%b want F/10", da_source, ua_ready); end
        idle_inputs();
    endtask

    task automatic test_outstanding();
        apply_reset();
        ua_valid = 2'b01; da_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            set_get(0, 3'(n), 14'(n * 4));
            @(negedge clock);
            if (n < MAX_OUT) begin
                checks++; if (ua_ready !== 2'b01) begin failures++; $display("FAIL out_accept%0d: got %b want 01", n, ua_ready); end
                next_cycle();
            end else begin
                checks++; if (ua_ready !== 2'b00 || da_valid !== 1'b0) begin failures++; $display("FAIL out_stall: got rdy=%b v=%b want 00/0", ua_ready, da_valid); end
            end
        end
        next_cycle();
        dd_valid = 1'b1; dd_opcode = 3'd1; dd_size = 4'd2; dd_source = 4'h3; dd_data = 32'hCAFE_0003; ud_ready = 2'b01;
        @(negedge clock);
        checks++; if (ud_valid !== 2'b01 || ud_source[0] !== 3'd3 || ud_data[0] !== 32'hCAFE_0003 || dd_ready !== 1'b1) begin
            failures++; $display("FAIL out_d: got v=%b src=%h data=%h rdy=%b want 01/3/cafe0003/1", ud_valid, ud_source[0], ud_data[0], dd_ready);
        end
        checks++; if (da_valid !== 1'b0) begin failures++; $display("FAIL out_still_stalled: got %b want 0", da_valid); end
        next_cycle();
        dd_valid = 1'b0;
        @(negedge clock);
        checks++; if (da_valid !== 1'b1 || da_source !== 4'h4 || ua_ready !== 2'b01) begin failures++; $display("FAIL out_release: got v=%b src=%h rdy=%b want 1/4/01", da_valid, da_source, ua_ready); end
        idle_inputs();
    endtask

    task automatic test_d_routing();
        apply_reset();
        ua_valid = 2'b10; da_ready = 1'b1;
        for (int n = 0; n < MAX_OUT; n++) begin
            set_get(1, 3'(n), 14'h40);
            next_cycle();
        end
        set_get(1, 3'd5, 14'h44);
        @(negedge clock);
        checks++; if (da_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL dr_saturated: got v=%b busy=%b want 0/1", da_valid, busy); end
        next_cycle();
        dd_valid = 1'b1; dd_opcode = 3'd1; dd_size = 4'd3; dd_source = 4'hA; dd_data = 32'h1111; ud_ready = 2'b01;
        @(negedge clock);
        checks++; if (dd_ready !== 1'b0 || ud_valid !== 2'b10) begin failures++; $display("FAIL dr_ready_steer: got rdy=%b v=%b want 0/10", dd_ready, ud_valid); end
        next_cycle();
        ud_ready = 2'b10;
        for (int b = 0; b < 2; b++) begin
            dd_data = 32'h1111 * 32'(b + 1);
            @(negedge clock);
            checks++; if (ud_valid !== 2'b10 || ud_source[1] !== 3'd2 || ud_data[1] !== 32'h1111 * 32'(b + 1) || dd_ready !== 1'b1) begin
                failures++; $display("FAIL dr_beat%0d: got v=%b src=%h data=%h rdy=%b want 10/2/%h/1", b, ud_valid, ud_source[1], ud_data[1], dd_ready, 32'h1111 * 32'(b + 1));
            end
            checks++; if (da_valid !== 1'b0) begin failures++; $display("FAIL dr_no_free%0d: got %b want 0", b, da_valid); end
            next_cycle();
        end
        dd_valid = 1'b0;
        @(negedge clock);
        checks++; if (da_valid !== 1'b1 || da_source !== 4'hD) begin failures++; $display("FAIL dr_freed: got v=%b src=%h want 1/D", da_valid, da_source); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        ua_valid = 2'b01; da_ready = 1'b1;
        ua_opcode[0] = 3'd0; ua_size[0] = 4'd4; ua_source[0] = 3'd2; ua_address[0] = 14'h500; ua_mask[0] = 4'hF;
        next_cycle();
        @(negedge clock);
        checks++; if (arb_state !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rmb_in_burst: got state=%b busy=%b want 1/1", arb_state, busy); end
        #1 reset = 1'b1;
        #1;
        checks++; if (da_valid !== 1'b0 || busy !== 1'b0 || arb_state !== 1'b0) begin
            failures++; $display("FAIL rmb_abort: got v=%b busy=%b state=%b want 0/0/0", da_valid, busy, arb_state);
        end
        ua_valid = 2'b11; set_get(0, 3'd1, 14'h10); set_get(1, 3'd5, 14'h50);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (da_source !== 4'h1) begin failures++; $display("FAIL rmb_first_winner: got %h want 1", da_source); end
        idle_inputs();
    endtask

    task automatic test_random();
        int g, k, dk, inc, dec;
        bit afire, dfire;
        logic [1:0] exp_rdy, exp_udv;
        apply_reset();
        m_last = 1; m_lock = 0; m_hold = -1; m_burst_left = 0; m_out = '{0, 0};
        g_act = '{0, 0}; d_act = 0; d_left = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!g_act[i] && $urandom_range(0, 2) != 0) begin
                    g_act[i] = 1'b1;
                    case ($urandom_range(0, 2))
                        0: g_op[i] = 3'd0;
                        1: g_op[i] = 3'd1;
                        default: g_op[i] = 3'd4;
                    endcase
                    g_size[i] = 4'($urandom_range(0, 4));
                    g_src[i] = 3'($urandom); g_addr[i] = 14'($urandom);
                    g_data[i] = $urandom; g_mask[i] = 4'($urandom);
                    g_left[i] = a_beats(g_op[i], g_size[i]);
                end
                ua_valid[i] = g_act[i]; ua_opcode[i] = g_op[i]; ua_size[i] = g_size[i];
                ua_source[i] = g_src[i]; ua_address[i] = g_addr[i]; ua_data[i] = g_data[i];
                ua_mask[i] = g_mask[i]; ua_param[i] = 3'd0;
            end
            if (!d_act) begin
                dk = $urandom_range(0, 1);
                if (m_out[dk] > 0 && $urandom_range(0, 1) == 1) begin
                    d_act = 1'b1; d_src = {dk[0], 3'($urandom)}; d_op = 3'($urandom_range(0, 1));
                    d_size = 4'($urandom_range(0, 4)); d_left = d_beats(d_op, d_size); d_data = $urandom;
                end
            end
            dd_valid = d_act; dd_source = d_src; dd_opcode = d_op; dd_size = d_size; dd_data = d_data;
            dd_param = 2'($urandom); dd_denied = 1'($urandom);
            da_ready = ($urandom_range(0, 3) != 0);
            ud_ready = 2'($urandom);
            @(negedge clock);
            g = exp_grant();
            exp_rdy = (g >= 0 && da_ready) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
            k = int'(dd_source[3]);
            exp_udv = d_act ? ((k == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (da_valid !== (g >= 0)) begin failures++; $display("FAIL rnd_da_valid c%0d: got %b want %b", cyc, da_valid, g >= 0); end
            if (g >= 0) begin
                checks++; if (da_source !== {g[0], g_src[g]} || {da_opcode, da_size, da_address, da_mask, da_data} !== {g_op[g], g_size[g], g_addr[g], g_mask[g], g_data[g]}) begin
                    failures++; $display("FAIL rnd_da_fields c%0d: got src=%h op=%0d addr=%h data=%h want src=%h op=%0d addr=%h data=%h",
                                         cyc, da_source, da_opcode, da_address, da_data, {g[0], g_src[g]}, g_op[g], g_addr[g], g_data[g]);
                end
            end
            checks++; if (ua_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ua_ready c%0d: got %b want %b", cyc, ua_ready, exp_rdy); end
            checks++; if (ud_valid !== exp_udv || dd_ready !== ud_ready[k]) begin failures++; $display("FAIL rnd_d_route c%0d: got v=%b rdy=%b want %b/%b", cyc, ud_valid, dd_ready, exp_udv, ud_ready[k]); end
            if (d_act) begin
                checks++; if (ud_source[k] !== d_src[2:0] || ud_data[k] !== d_data || ud_opcode[k] !== d_op) begin
                    failures++; $display("FAIL rnd_ud_fields c%0d: got src=%h data=%h want src=%h data=%h", cyc, ud_source[k], ud_data[k], d_src[2:0], d_data);
                end
            end
            checks++; if (busy !== (m_burst_left > 0 || m_out[0] > 0 || m_out[1] > 0) || arb_state !== (m_burst_left > 0)) begin
                failures++; $display("FAIL rnd_busy c%0d: got busy=%b state=%b want %b/%b", cyc, busy, arb_state, m_burst_left > 0 || m_out[0] > 0 || m_out[1] > 0, m_burst_left > 0);
            end
            afire = (g >= 0) && da_ready;
            inc = -1; dec = -1;
            if (afire) begin
                if (m_burst_left == 0) begin
                    m_last = g; inc = g;
                    if (g_left[g] > 1) begin m_burst_left = g_left[g] - 1; m_lock = g; end
                end else begin
                    m_burst_left--;
                end
                m_hold = -1;
                g_left[g]--;
                if (g_left[g] == 0) g_act[g] = 1'b0;
                else begin g_data[g] = $urandom; g_mask[g] = 4'($urandom); end
            end else if (m_burst_left == 0) begin
                m_hold = g;
            end
            dfire = d_act && ud_ready[k];
            if (dfire) begin
                d_left--;
                if (d_left == 0) begin d_act = 1'b0; dec = k; end
                else d_data = $urandom;
            end
            if (inc >= 0) m_out[inc]++;
            if (dec >= 0) m_out[dec]--;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alternate();
        test_burst_lock();
        test_backpressure();
        test_outstanding();
        test_d_routing();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
